mips_id_stage: RTL
==================

Name: mips_id_stage

Overview:
- Instruction-decode stage plus ID/EX pipeline register for the 5-stage MIPS core. This block produces the exe_cmd/val1/val2 operands that the EX-stage ALU consumes.
- Decodes a MIPS32 integer subset and selects operands from register-file read data and immediates.
- Detects load-use hazards and inserts bubbles.
- Honours downstream stall and branch flush.

Parameters:
- DATA_W, 32, datapath width (fixed at 32; parameterised only for package constants).
- RESET_PC, 32'h0000_0000, value loaded into ex_pc on reset.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  IF/ID register holds a real instruction.
- if_instr  in  32  instruction word.
- if_pc  in  32  address of if_instr.
- rs_addr  out  32→5  combinational: if_instr[25:21] to register file.
- rt_addr  out  5  combinational: if_instr[20:16] to register file.
- rf_rd1  in  32  register file data for rs (combinational read).
- rf_rd2  in  32  register file data for rt.
- exe_stall  in  1  downstream freeze; hold ID/EX register.
- flush  in  1  branch/jump taken in EX; kill instruction in ID.
- stall_if  out  1  combinational; IF/ID must hold its contents this cycle.
- ex_valid  out  1  ID/EX holds a real instruction.
- ex_exe_cmd  out  4  ALU command.
- ex_val1, ex_val2  out  32  ALU operands.
- ex_st_data  out  32  store data (rt).
- ex_dest  out  5  writeback register.
- ex_wb_en, ex_mem_rd, ex_mem_wr  out  1 each  control bits.
- ex_br_type  out  2  0 none, 1 beq, 2 bne, 3 jump.
- ex_br_target  out  32  branch/jump target.
- ex_pc  out  32  pc of issued instruction.
- ex_illegal  out  1  one-cycle flag for an unrecognised opcode or funct.

Behaviour:
- Reset: while rst_n=0, all registered outputs are 0 asynchronously, except ex_pc=RESET_PC.
- Latency: one cycle. Decode is combinational from the IF/ID inputs; results are registered on the next edge.
- exe_cmd encodings: 0 add, 2 sub, 4 and, 5 or, 6 nor, 7 xor, 8 sll, 9 sra, 10 srl.
- R-type, opcode 0:
  - funct 20/21 → add; 22/23 → sub; 24 and; 25 or; 26 xor; 27 nor. val1=rf_rd1, val2=rf_rd2.
  - sll 00, srl 02, sra 03: val1=rf_rd2, val2=zero-extended shamt.
  - sllv 04, srlv 06, srav 07: val1=rf_rd2, val2=rf_rd1.
  - dest=rd.
- I-type, dest=rt:
  - addi 08 / addiu 09 → add with sign-extended imm.
  - andi 0C / ori 0D / xori 0E use zero-extended imm.
  - lui 0F: cmd 8, val1={16'b0,imm}, val2=16.
  - lw 23: add, rs+sext imm, mem_rd=1.
- sw 2B: add, rs+sext imm, mem_wr=1, st_data=rf_rd2, dest=0, wb_en=0.
- beq 04 / bne 05:
  - cmd 2, val1=rf_rd1, val2=rf_rd2, br_type 1/2.
  - target = pc+4+(sext imm<<2).
  - dest=0, wb_en=0.
- j 02: br_type 3, target={pc+4[31:28], instr[25:0], 2'b00}, wb_en=0.
- wb_en=1 only for writing instruction types with dest≠0. Instruction word 0 therefore decodes as a true NOP.
- Unrecognised opcode or funct: issue a bubble and set ex_illegal=1 for that cycle.
- Bubble: ex_valid, wb_en, mem_rd, mem_wr, br_type, exe_cmd, val1, val2, st_data, dest, br_target all 0. ex_pc takes if_pc.
- Load-use hazard (H), all of the following true:
  - ex_valid & ex_mem_rd & ex_dest≠0 & if_valid;
  - ex_dest equals an rs or rt the current instruction actually reads. Shamt shifts do not read rs; lui and j read neither; I-types other than sw/beq/bne do not read rt.
- Per-edge priority:
  1. exe_stall=1: hold all ID/EX outputs; stall_if=1.
  2. Else flush=1: load a bubble; stall_if=0, H ignored.
  3. Else H=1: load a bubble; stall_if=1. On the next cycle ex_mem_rd=0, so the instruction issues.
  4. Else if_valid=0: load a bubble.
  5. Else load the decoded instruction.
- stall_if = exe_stall | (H & ~flush).
- Reset mid-stall drops the held instruction. No state survives reset.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct localparams;
  - EXE_CMD encodings, which the ALU must also import;
  - BR_TYPE encodings;
  - a struct/bus layout for the ID/EX control bundle.
- Sub-module mips_decoder is purely combinational: instr, pc, rf_rd1, rf_rd2 → control bundle, uses_rs, uses_rt, illegal. The top level holds the hazard logic and the ID/EX register.

Test Plan:
- Reset: assert rst_n=0 mid-stream with ex_valid=1 → all outputs 0 immediately without a clock edge; ex_pc=RESET_PC.
- add $3,$1,$2 (0x00221820), rf_rd1=5, rf_rd2=7 → next edge: ex_exe_cmd=0, val1=5, val2=7, dest=3, wb_en=1, ex_valid=1.
- Immediates:
  - addi $1,$0,-1 (0x2001FFFF) → val2=0xFFFFFFFF.
  - andi (0x3001FFFF) → val2=0x0000FFFF.
  - sra $5,$6,3 (0x000628C3) with rf_rd2=0x80000000 → cmd 9, val1=0x80000000, val2=3.
- Load-use: lw $2,4($1) (0x8C220004) then add $3,$2,$4 (0x00441820):
  - cycle after lw issues → stall_if=1 and a bubble is loaded;
  - following edge → add issues with dest=3.
  - Repeat with the add replaced by sll $3,$0,0 → no stall.
- Stall/flush:
  - exe_stall held 3 cycles → outputs bit-stable, stall_if=1.
  - flush=1 with valid beq → bubble, stall_if=0.
  - exe_stall and flush together → hold wins.
- Illegal: opcode 0x3F → ex_illegal=1 for one cycle, ex_valid=0, wb_en=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the ID/EX control bundle layout.
// The ALU imports the EXE_* command encodings from here as well.
package mips_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [3:0] EXE_ADD = 4'd0;
  localparam logic [3:0] EXE_SUB = 4'd2;
  localparam logic [3:0] EXE_AND = 4'd4;
  localparam logic [3:0] EXE_OR  = 4'd5;
  localparam logic [3:0] EXE_NOR = 4'd6;
  localparam logic [3:0] EXE_XOR = 4'd7;
  localparam logic [3:0] EXE_SLL = 4'd8;
  localparam logic [3:0] EXE_SRA = 4'd9;
  localparam logic [3:0] EXE_SRL = 4'd10;

  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_BEQ  = 2'd1;
  localparam logic [1:0] BR_BNE  = 2'd2;
  localparam logic [1:0] BR_JUMP = 2'd3;

  typedef struct packed {
    logic [3:0]  exe_cmd;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_data;
    logic [4:0]  dest;
    logic        wb_en;
    logic        mem_rd;
    logic        mem_wr;
    logic [1:0]  br_type;
    logic [31:0] br_target;
  } id_ex_ctrl_t;

  function automatic logic [31:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_decoder.sv
// Purely combinational MIPS32 subset decoder: builds the ID/EX control bundle
// and reports which source registers the instruction really reads.
module mips_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rf_rd1,
  input  logic [31:0] rf_rd2,
  output id_ex_ctrl_t ctrl,
  output logic        uses_rs,
  output logic        uses_rt,
  output logic        illegal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic [31:0] pc_plus4;
  logic        writes;

  assign opcode   = instr[31:26];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm      = instr[15:0];
  assign imm_s    = sext16(imm);
  assign imm_z    = {16'b0, imm};
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    ctrl    = '0;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    illegal = 1'b0;
    writes  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl.dest = rd;
        ctrl.val1 = rf_rd1;
        ctrl.val2 = rf_rd2;
        writes    = 1'b1;
        uses_rs   = 1'b1;
        uses_rt   = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: ctrl.exe_cmd = EXE_ADD;
          FN_SUB, FN_SUBU: ctrl.exe_cmd = EXE_SUB;
          FN_AND:          ctrl.exe_cmd = EXE_AND;
          FN_OR:           ctrl.exe_cmd = EXE_OR;
          FN_XOR:          ctrl.exe_cmd = EXE_XOR;
          FN_NOR:          ctrl.exe_cmd = EXE_NOR;
          // Immediate shifts take the amount from the instruction, so rs is not read
          FN_SLL, FN_SRL, FN_SRA: begin
            ctrl.exe_cmd = (funct == FN_SLL) ? EXE_SLL :
                           (funct == FN_SRL) ? EXE_SRL : EXE_SRA;
            ctrl.val1    = rf_rd2;
            ctrl.val2    = {27'b0, shamt};
            uses_rs      = 1'b0;
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            ctrl.exe_cmd = (funct == FN_SLLV) ? EXE_SLL :
                           (funct == FN_SRLV) ? EXE_SRL : EXE_SRA;
            ctrl.val1    = rf_rd2;
            ctrl.val2    = rf_rd1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI: begin
        ctrl.dest = rt;
        ctrl.val1 = rf_rd1;
        writes    = 1'b1;
        uses_rs   = 1'b1;
        case (opcode)
          OP_ANDI: begin ctrl.exe_cmd = EXE_AND; ctrl.val2 = imm_z; end
          OP_ORI:  begin ctrl.exe_cmd = EXE_OR;  ctrl.val2 = imm_z; end
          OP_XORI: begin ctrl.exe_cmd = EXE_XOR; ctrl.val2 = imm_z; end
          default: begin ctrl.exe_cmd = EXE_ADD; ctrl.val2 = imm_s; end
        endcase
      end
      OP_LUI: begin
        ctrl.exe_cmd = EXE_SLL;
        ctrl.val1    = imm_z;
        ctrl.val2    = 32'd16;
        ctrl.dest    = rt;
        writes       = 1'b1;
      end
      OP_LW: begin
        ctrl.exe_cmd = EXE_ADD;
        ctrl.val1    = rf_rd1;
        ctrl.val2    = imm_s;
        ctrl.dest    = rt;
        ctrl.mem_rd  = 1'b1;
        writes       = 1'b1;
        uses_rs      = 1'b1;
      end
      OP_SW: begin
        ctrl.exe_cmd = EXE_ADD;
        ctrl.val1    = rf_rd1;
        ctrl.val2    = imm_s;
        ctrl.st_data = rf_rd2;
        ctrl.mem_wr  = 1'b1;
        uses_rs      = 1'b1;
        uses_rt      = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.exe_cmd   = EXE_SUB;
        ctrl.val1      = rf_rd1;
        ctrl.val2      = rf_rd2;
        ctrl.br_type   = (opcode == OP_BEQ) ? BR_BEQ : BR_BNE;
        ctrl.br_target = pc_plus4 + {imm_s[29:0], 2'b00};
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_J: begin
        ctrl.br_type   = BR_JUMP;
        ctrl.br_target = {pc_plus4[31:28], instr[25:0], 2'b00};
      end
      default: illegal = 1'b1;
    endcase

    // An illegal word must look exactly like a bubble and must not trigger a hazard
    if (illegal) begin
      ctrl    = '0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      writes  = 1'b0;
    end
    ctrl.wb_en = writes & (ctrl.dest != 5'd0);
  end

endmodule

// File: rtl/mips_id_stage.sv
// MIPS instruction-decode stage with load-use hazard detection and the ID/EX
// pipeline register feeding the EX-stage ALU.
module mips_id_stage
  import mips_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [31:0]       if_pc,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              exe_stall,
  input  logic              flush,
  output logic              stall_if,
  output logic              ex_valid,
  output logic [3:0]        ex_exe_cmd,
  output logic [DATA_W-1:0] ex_val1,
  output logic [DATA_W-1:0] ex_val2,
  output logic [DATA_W-1:0] ex_st_data,
  output logic [4:0]        ex_dest,
  output logic              ex_wb_en,
  output logic              ex_mem_rd,
  output logic              ex_mem_wr,
  output logic [1:0]        ex_br_type,
  output logic [31:0]       ex_br_target,
  output logic [31:0]       ex_pc,
  output logic              ex_illegal
);

  id_ex_ctrl_t dec_ctrl;
  id_ex_ctrl_t ex_ctrl_q;
  logic        dec_uses_rs;
  logic        dec_uses_rt;
  logic        dec_illegal;
  logic        load_use;
  logic        ex_valid_q;
  logic        ex_illegal_q;
  logic [31:0] ex_pc_q;

  assign rs_addr = if_instr[25:21];
  assign rt_addr = if_instr[20:16];

  mips_decoder u_decoder (
    .instr   (if_instr),
    .pc      (if_pc),
    .rf_rd1  (rf_rd1),
    .rf_rd2  (rf_rd2),
    .ctrl    (dec_ctrl),
    .uses_rs (dec_uses_rs),
    .uses_rt (dec_uses_rt),
    .illegal (dec_illegal)
  );

  // A load in EX cannot forward to ID in time, so a consumer must wait one cycle
  assign load_use = ex_valid_q & ex_ctrl_q.mem_rd & (ex_ctrl_q.dest != 5'd0) & if_valid &
                    ((dec_uses_rs & (rs_addr == ex_ctrl_q.dest)) |
                     (dec_uses_rt & (rt_addr == ex_ctrl_q.dest)));

  assign stall_if = exe_stall | (load_use & ~flush);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q    <= '0;
      ex_valid_q   <= 1'b0;
      ex_illegal_q <= 1'b0;
      ex_pc_q      <= RESET_PC;
    end else if (!exe_stall) begin
      ex_pc_q <= if_pc;
      if (flush | load_use | ~if_valid | dec_illegal) begin
        ex_ctrl_q    <= '0;
        ex_valid_q   <= 1'b0;
        ex_illegal_q <= dec_illegal & if_valid & ~flush & ~load_use;
      end else begin
        ex_ctrl_q    <= dec_ctrl;
        ex_valid_q   <= 1'b1;
        ex_illegal_q <= 1'b0;
      end
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_exe_cmd   = ex_ctrl_q.exe_cmd;
  assign ex_val1      = ex_ctrl_q.val1;
  assign ex_val2      = ex_ctrl_q.val2;
  assign ex_st_data   = ex_ctrl_q.st_data;
  assign ex_dest      = ex_ctrl_q.dest;
  assign ex_wb_en     = ex_ctrl_q.wb_en;
  assign ex_mem_rd    = ex_ctrl_q.mem_rd;
  assign ex_mem_wr    = ex_ctrl_q.mem_wr;
  assign ex_br_type   = ex_ctrl_q.br_type;
  assign ex_br_target = ex_ctrl_q.br_target;
  assign ex_pc        = ex_pc_q;
  assign ex_illegal   = ex_illegal_q;

endmodule
